// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the arbitrated SPI master.
//   spi_state_t : transaction FSM states
//   SPI_WIDTH   : bits per SPI transfer
//   clog2()     : ceiling log2 usable in parameter expressions
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    SETUP = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } spi_state_t;

  // Returns ceil(log2(value)); 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_clk_gen
// Generates SCLK from the system clock while enabled. SCLK starts low, and
// the first enabled cycle produces a rise strobe; after that SCLK toggles
// every DIV cycles. Dropping i_en returns SCLK low and restarts the counter.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_en    : run enable from the FSM
//   o_sclk  : registered serial clock
//   o_rise  : SCLK goes high on the coming clk edge
//   o_fall  : SCLK goes low on the coming clk edge
// ---------------------------------------------------------------------------
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (DIV > 1) ? clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_tick;

  // A tick marks the edge on which SCLK toggles.
  assign w_tick = i_en && (r_cnt == '0);
  assign o_rise = w_tick && !r_sclk;
  assign o_fall = w_tick && r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_cnt <= (r_cnt == CW'(DIV - 1)) ? '0 : r_cnt + 1'b1;
      if (w_tick) r_sclk <= ~r_sclk;
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// ---------------------------------------------------------------------------
// spi_master_arbiter
// Round-robin shared SPI master. Each requester offers one byte plus a slave
// index; the winner's byte is shifted LSB-first on MOSI while the reply is
// captured from MISO and returned on rx_data.
//   clk, reset          : system clock, asynchronous active-low reset
//   req/req_data/req_sel: per-requester request, byte, slave index
//   gnt                 : one-cycle pulse, request data latched
//   done                : one-cycle pulse to the owner at end of transfer
//   rx_data             : received byte, valid from done to next done
//   busy                : transaction in progress
//   SCLK/CS/MOSI/MISO   : SPI bus (SCLK idles low, CS active low)
//
// Handshake: a requester holds req with stable req_data/req_sel until it
// sees its gnt bit; the byte is latched in that cycle, so anything the
// requester changes afterwards belongs to its next transfer. Keeping req
// high queues another transfer. done marks the cycle rx_data is updated.
// ---------------------------------------------------------------------------
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int NSLAVE = 4,
  parameter int DIV    = 3,
  parameter int SELW   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [8*NREQ-1:0]      req_data,
  input  logic [SELW*NREQ-1:0]   req_sel,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [SPI_WIDTH-1:0]   rx_data,
  output logic                   busy,
  output logic                   SCLK,
  output logic [NSLAVE-1:0]      CS,
  output logic                   MOSI,
  input  logic                   MISO
);

  localparam int PW = (NREQ > 1) ? clog2(NREQ) : 1;
  localparam int CW = clog2(16 * DIV + 1);

  spi_state_t           r_state;
  logic [CW-1:0]        r_cnt;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_owner;
  logic [SPI_WIDTH-1:0] r_tx;
  logic [SPI_WIDTH-1:0] r_rx;
  logic [SELW-1:0]      r_sel;
  logic [2:0]           r_bit;
  logic [NREQ-1:0]      r_gnt;
  logic [NREQ-1:0]      r_done;
  logic [SPI_WIDTH-1:0] r_rx_data;
  logic                 r_busy;
  logic [NSLAVE-1:0]    r_cs;
  logic                 r_mosi;

  logic                 w_sclk;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_any;
  logic [PW-1:0]        w_win;
  int                   w_idx;
  logic [NSLAVE-1:0]    w_cs_next;

  spi_clk_gen #(.DIV(DIV)) u_clk_gen (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_en    (r_state == SHIFT),
    .o_sclk  (w_sclk),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Round-robin pick: scan from r_ptr upward with wrap. Walking the offsets
  // from highest to lowest lets the closest requester overwrite the others.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_idx = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = (int'(r_ptr) + i) % NREQ;
      if (req[w_idx]) begin
        w_win = PW'(w_idx);
        w_any = 1'b1;
      end
    end
  end

  // Chip-select decode; an index >= NSLAVE matches no line.
  always_comb begin
    w_cs_next = '1;
    if (r_state == SETUP || r_state == SHIFT || r_state == HOLD) begin
      for (int i = 0; i < NSLAVE; i++) begin
        if (int'(r_sel) == i) w_cs_next[i] = 1'b0;
      end
    end
  end

  // Bus outputs are registered from the current state, so they trail the
  // state by one cycle: SETUP entered with the grant shows CS one cycle
  // later. GAP therefore runs DIV+1 cycles so the bus sees DIV idle cycles
  // plus the arbitration cycle before the next grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_sel     <= '0;
      r_bit     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_rx_data <= '0;
      r_busy    <= 1'b0;
      r_cs      <= '1;
      r_mosi    <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      r_cs   <= w_cs_next;
      case (r_state)
        IDLE: begin
          if (|req) r_state <= ARB;
        end
        ARB: begin
          if (w_any) begin
            r_gnt   <= NREQ'(1) << w_win;
            r_owner <= w_win;
            r_tx    <= req_data[8*int'(w_win) +: 8];
            r_sel   <= req_sel[SELW*int'(w_win) +: SELW];
            r_ptr   <= (int'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= SETUP;
          end else begin
            r_state <= IDLE;
          end
        end
        SETUP: begin
          r_mosi <= r_tx[0];
          if (r_cnt == CW'(DIV - 1)) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (w_rise) r_mosi <= r_tx[r_bit];
          if (w_fall) begin
            r_rx  <= {MISO, r_rx[SPI_WIDTH-1:1]};
            r_bit <= r_bit + 1'b1;
          end
          if (r_cnt == CW'(16 * DIV - 1)) begin
            r_cnt   <= '0;
            r_state <= HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (r_cnt == CW'(DIV - 1)) begin
            r_cnt   <= '0;
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP: begin
          // First GAP cycle lines up done/rx_data with CS rising.
          if (r_cnt == '0) begin
            r_done    <= NREQ'(1) << r_owner;
            r_rx_data <= r_rx;
          end
          if (r_cnt == CW'(DIV)) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= (|req) ? ARB : IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign busy    = r_busy;
  assign SCLK    = w_sclk;
  assign CS      = r_cs;
  assign MOSI    = r_mosi;

endmodule
